// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
// Optional feature macro used by this slice: RF_WB_BYPASS_EN.
package rf_ctrl_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int REGISTERS_DEF      = 32;
  localparam int LOG2_REGISTERS_DEF = 5;

  // Grant-vector bit positions follow the encoding of this enum.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  localparam int X0_IDX = 0;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback, issue and register-file bus of the writeback scheduler.
// Bypass signals exist only when RF_WB_BYPASS_EN is defined.
interface regfile_wb_scheduler_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int LOG2_REGISTERS = 5
);
  logic                      alu_valid;
  logic                      alu_ready;
  logic [LOG2_REGISTERS-1:0] alu_rd;
  logic [DATA_WIDTH-1:0]     alu_data;
  logic                      lsu_valid;
  logic                      lsu_ready;
  logic [LOG2_REGISTERS-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0]     lsu_data;
  logic                      iss_valid;
  logic [LOG2_REGISTERS-1:0] iss_rs1;
  logic [LOG2_REGISTERS-1:0] iss_rs2;
  logic [LOG2_REGISTERS-1:0] iss_rd;
  logic                      iss_stall;
  logic                      rf_enable;
  logic [LOG2_REGISTERS-1:0] addr_rd;
  logic [DATA_WIDTH-1:0]     data_rd;
`ifdef RF_WB_BYPASS_EN
  logic                      byp_rs1_hit;
  logic                      byp_rs2_hit;
  logic [DATA_WIDTH-1:0]     byp_data;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rs1, iss_rs2, iss_rd,
    input  alu_ready, lsu_ready, iss_stall,
    input  rf_enable, addr_rd, data_rd
`ifdef RF_WB_BYPASS_EN
    , input byp_rs1_hit, byp_rs2_hit, byp_data
`endif
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rs1, iss_rs2, iss_rd,
    output alu_ready, lsu_ready, iss_stall,
    output rf_enable, addr_rd, data_rd
`ifdef RF_WB_BYPASS_EN
    , output byp_rs1_hit, byp_rs2_hit, byp_data
`endif
  );

endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer remembers the last source
// that won a conflict and only moves when a conflict is resolved.
module rr_arbiter2
  import rf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e last_src;

  always_comb begin
    gnt = req;
    if (req[0] && req[1])
      gnt = (last_src == SRC_LSU) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_src <= SRC_LSU;
    else if (req[0] && req[1])
      last_src <= gnt[0] ? SRC_ALU : SRC_LSU;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: ALU/LSU round-robin arbitration,
// registered write stage and in-flight destination scoreboard.
// Optional operand bypass from the write stage: RF_WB_BYPASS_EN.
module regfile_wb_scheduler
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REGISTERS      = REGISTERS_DEF,
  parameter int LOG2_REGISTERS = LOG2_REGISTERS_DEF
)(
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_scheduler_if.slave  bus
);

  localparam logic [LOG2_REGISTERS-1:0] X0 = LOG2_REGISTERS'(X0_IDX);

  logic [1:0]                gnt;
  logic                      any_gnt;
  logic [LOG2_REGISTERS-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_data;

  logic                      rf_enable_q;
  logic [LOG2_REGISTERS-1:0] addr_rd_q;
  logic [DATA_WIDTH-1:0]     data_rd_q;

  logic [REGISTERS-1:0]      pending;
  logic [REGISTERS-1:0]      set_vec;
  logic [REGISTERS-1:0]      clr_vec;
  logic                      rs1_block;
  logic                      rs2_block;
  logic                      stall;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.lsu_valid, bus.alu_valid}),
    .gnt (gnt)
  );

  assign bus.alu_ready = gnt[0];
  assign bus.lsu_ready = gnt[1];
  assign any_gnt       = |gnt;
  assign wb_rd         = gnt[1] ? bus.lsu_rd   : bus.alu_rd;
  assign wb_data       = gnt[1] ? bus.lsu_data : bus.alu_data;

  // x0 grants are consumed but never reach the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_enable_q <= 1'b0;
      addr_rd_q   <= '0;
      data_rd_q   <= '0;
    end else begin
      rf_enable_q <= any_gnt && (wb_rd != X0);
      if (any_gnt && (wb_rd != X0)) begin
        addr_rd_q <= wb_rd;
        data_rd_q <= wb_data;
      end
    end
  end

  assign bus.rf_enable = rf_enable_q;
  assign bus.addr_rd   = addr_rd_q;
  assign bus.data_rd   = data_rd_q;

`ifdef RF_WB_BYPASS_EN
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit         = rf_enable_q && (addr_rd_q == bus.iss_rs1) && (addr_rd_q != X0);
  assign rs2_hit         = rf_enable_q && (addr_rd_q == bus.iss_rs2) && (addr_rd_q != X0);
  assign rs1_block       = pending[bus.iss_rs1] && !rs1_hit;
  assign rs2_block       = pending[bus.iss_rs2] && !rs2_hit;
  assign bus.byp_rs1_hit = rs1_hit;
  assign bus.byp_rs2_hit = rs2_hit;
  assign bus.byp_data    = data_rd_q;
`else
  assign rs1_block = pending[bus.iss_rs1];
  assign rs2_block = pending[bus.iss_rs2];
`endif

  assign stall         = bus.iss_valid && (rs1_block || rs2_block || pending[bus.iss_rd]);
  assign bus.iss_stall = stall;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (bus.iss_valid && !stall && (bus.iss_rd != X0))
      set_vec[bus.iss_rd] = 1'b1;
    if (rf_enable_q)
      clr_vec[addr_rd_q] = 1'b1;
  end

  // Set is OR-ed after the clear so a new producer outlives a retiring one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pending <= '0;
    else
      pending <= ((pending & ~clr_vec) | set_vec) & ~REGISTERS'(1);
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: arbitration, write stage,
// scoreboard hazards, x0 handling and asynchronous reset.
module tb_regfile_wb_scheduler;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  regfile_wb_scheduler_if #(.DATA_WIDTH(32), .LOG2_REGISTERS(5)) bus ();

  regfile_wb_scheduler #(
    .DATA_WIDTH     (32),
    .REGISTERS      (32),
    .LOG2_REGISTERS (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd);
    bus.iss_valid = v;
    bus.iss_rs1   = rs1;
    bus.iss_rs2   = rs2;
    bus.iss_rd    = rd;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.lsu_valid = v;
    bus.lsu_rd    = rd;
    bus.lsu_data  = d;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    alu(1'b0, 5'd0, 32'h0);
    lsu(1'b0, 5'd0, 32'h0);
    issue(1'b0, 5'd0, 5'd0, 5'd0);

    // Reset values settle before any clock edge
    #2;
    chk("rst_rf_enable", 64'(bus.rf_enable), 64'd0);
    chk("rst_addr_rd",   64'(bus.addr_rd),   64'd0);
    chk("rst_data_rd",   64'(bus.data_rd),   64'd0);
    chk("rst_stall",     64'(bus.iss_stall), 64'd0);
    step();
    rst = 1'b1;

    // Single ALU write, one-cycle latency
    alu(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("t1_alu_ready", 64'(bus.alu_ready), 64'd1);
    chk("t1_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    step();
    alu(1'b0, 5'd0, 32'h0);
    #1;
    chk("t1_rf_enable", 64'(bus.rf_enable), 64'd1);
    chk("t1_addr_rd",   64'(bus.addr_rd),   64'd5);
    chk("t1_data_rd",   64'(bus.data_rd),   64'hDEADBEEF);
    step();
    chk("t1_idle_en",   64'(bus.rf_enable), 64'd0);
    chk("t1_addr_hold", 64'(bus.addr_rd),   64'd5);

    // Conflict: ALU wins first after reset, LSU follows
    alu(1'b1, 5'd1, 32'h11);
    lsu(1'b1, 5'd2, 32'h22);
    #1;
    chk("t2_alu_ready", 64'(bus.alu_ready), 64'd1);
    chk("t2_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    step();
    alu(1'b0, 5'd0, 32'h0);
    #1;
    chk("t2_lsu_ready2", 64'(bus.lsu_ready), 64'd1);
    chk("t2_en_x1",      64'(bus.rf_enable), 64'd1);
    chk("t2_addr_x1",    64'(bus.addr_rd),   64'd1);
    chk("t2_data_x1",    64'(bus.data_rd),   64'h11);
    step();
    lsu(1'b0, 5'd0, 32'h0);
    #1;
    chk("t2_en_x2",   64'(bus.rf_enable), 64'd1);
    chk("t2_addr_x2", 64'(bus.addr_rd),   64'd2);
    chk("t2_data_x2", 64'(bus.data_rd),   64'h22);

    // Next conflict goes to LSU since ALU won the last one
    alu(1'b1, 5'd8, 32'h88);
    lsu(1'b1, 5'd9, 32'h99);
    #1;
    chk("t2b_lsu_ready", 64'(bus.lsu_ready), 64'd1);
    chk("t2b_alu_ready", 64'(bus.alu_ready), 64'd0);
    step();
    lsu(1'b0, 5'd0, 32'h0);
    #1;
    chk("t2b_addr_x9",   64'(bus.addr_rd),   64'd9);
    chk("t2b_alu_ready2", 64'(bus.alu_ready), 64'd1);
    step();
    alu(1'b0, 5'd0, 32'h0);
    #1;
    chk("t2b_addr_x8", 64'(bus.addr_rd), 64'd8);
    step();

    // RAW hazard on x7
    issue(1'b1, 5'd0, 5'd0, 5'd7);
    #1;
    chk("t3_issue_rd7", 64'(bus.iss_stall), 64'd0);
    step();
    issue(1'b1, 5'd7, 5'd0, 5'd0);
    #1;
    chk("t3_stall_a", 64'(bus.iss_stall), 64'd1);
    step();
    alu(1'b1, 5'd7, 32'h77);
    #1;
    chk("t3_stall_b", 64'(bus.iss_stall), 64'd1);
    step();
    alu(1'b0, 5'd0, 32'h0);
    #1;
    chk("t3_en_x7", 64'(bus.rf_enable), 64'd1);
`ifdef RF_WB_BYPASS_EN
    chk("t3_stall_wb",  64'(bus.iss_stall),   64'd0);
    chk("t3_byp_hit1",  64'(bus.byp_rs1_hit), 64'd1);
    chk("t3_byp_hit2",  64'(bus.byp_rs2_hit), 64'd0);
    chk("t3_byp_data",  64'(bus.byp_data),    64'h77);
`else
    chk("t3_stall_wb",  64'(bus.iss_stall),   64'd1);
`endif
    step();
    chk("t3_stall_clr", 64'(bus.iss_stall), 64'd0);
    step();
    issue(1'b0, 5'd0, 5'd0, 5'd0);

    // Issue to x7 at the edge a non-pending x7 write retires: set wins
    alu(1'b1, 5'd7, 32'h70);
    step();
    alu(1'b0, 5'd0, 32'h0);
    issue(1'b1, 5'd0, 5'd0, 5'd7);
    #1;
    chk("t4_en_x7",    64'(bus.rf_enable), 64'd1);
    chk("t4_issue_ok", 64'(bus.iss_stall), 64'd0);
    step();
    issue(1'b1, 5'd0, 5'd7, 5'd0);
    #1;
    chk("t4_rs2_stall", 64'(bus.iss_stall), 64'd1);
    issue(1'b0, 5'd0, 5'd7, 5'd0);
    #1;
    chk("t4_novalid", 64'(bus.iss_stall), 64'd0);

    // LSU write to x0 is accepted and dropped
    lsu(1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    chk("t5_lsu_ready", 64'(bus.lsu_ready), 64'd1);
    step();
    lsu(1'b0, 5'd0, 32'h0);
    issue(1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    chk("t5_rf_enable", 64'(bus.rf_enable), 64'd0);
    chk("t5_addr_hold", 64'(bus.addr_rd),   64'd7);
    chk("t5_x0_stall",  64'(bus.iss_stall), 64'd0);
    step();

    // Reset mid-stream with x3/x4 pending and a write in flight
    issue(1'b1, 5'd0, 5'd0, 5'd3);
    step();
    issue(1'b1, 5'd0, 5'd0, 5'd4);
    #1;
    chk("t6_issue_rd4", 64'(bus.iss_stall), 64'd0);
    step();
    issue(1'b0, 5'd0, 5'd0, 5'd0);
    alu(1'b1, 5'd3, 32'h33);
    step();
    alu(1'b0, 5'd0, 32'h0);
    #1;
    chk("t6_en_x3", 64'(bus.rf_enable), 64'd1);
    rst = 1'b0;
    #1;
    chk("t6_rst_en",   64'(bus.rf_enable), 64'd0);
    chk("t6_rst_addr", 64'(bus.addr_rd),   64'd0);
    chk("t6_rst_data", 64'(bus.data_rd),   64'd0);
    rst = 1'b1;
    issue(1'b1, 5'd3, 5'd4, 5'd0);
    #1;
    chk("t6_rs_after_rst", 64'(bus.iss_stall), 64'd0);
    step();
    issue(1'b0, 5'd0, 5'd0, 5'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
